// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store access unit: data width, RISC-V
// width codes, FSM state encoding and the access-legality check.
// Latency: n/a (definitions only). Backpressure: n/a.
package mem_access_unit_pkg;

  localparam int XLEN = 64;

  // funct3 width codes (loads use all seven, stores use the low four)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Flags an access that must not touch memory: unsupported width code
  // (unsigned store or funct3 111 load) or not naturally aligned.
  function automatic logic access_error(input logic       is_store,
                                        input logic [2:0] funct3,
                                        input logic [2:0] lane);
    logic err;
    err = 1'b0;
    if (is_store && funct3[2]) begin
      err = 1'b1;
    end else if (funct3 == 3'b111) begin
      err = 1'b1;
    end else begin
      case (funct3[1:0])
        2'b01:   err = lane[0];
        2'b10:   err = |lane[1:0];
        2'b11:   err = |lane;
        default: err = 1'b0;
      endcase
    end
    return err;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane extract/extend for loads and byte-lane merge for sub-doubleword stores.
// Latency: purely combinational. Backpressure: none.
// Ports: funct3_i width code, lane_i = addr[2:0], dword_i memory doubleword,
//        wdata_i LSB-aligned store data, load_o extended load, merge_o merged store doubleword.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [2:0]      lane_i,
  input  logic [XLEN-1:0] dword_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] load_o,
  output logic [XLEN-1:0] merge_o
);

  logic [5:0]      bit_off;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] size_mask;
  logic [XLEN-1:0] lane_mask;

  assign bit_off = {lane_i, 3'b000};
  // Addressed bytes moved down to bit 0 so extension works on fixed slices.
  assign shifted = dword_i >> bit_off;

  always_comb begin
    load_o = '0;
    case (funct3_i)
      F3_B:    load_o = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
      F3_H:    load_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_W:    load_o = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      F3_D:    load_o = shifted;
      F3_BU:   load_o = {{(XLEN-8){1'b0}},  shifted[7:0]};
      F3_HU:   load_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
      F3_WU:   load_o = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: load_o = '0;
    endcase
  end

  always_comb begin
    size_mask = '1;
    case (funct3_i[1:0])
      2'b00:   size_mask = {{(XLEN-8){1'b0}},  8'hFF};
      2'b01:   size_mask = {{(XLEN-16){1'b0}}, 16'hFFFF};
      2'b10:   size_mask = {{(XLEN-32){1'b0}}, 32'hFFFF_FFFF};
      default: size_mask = '1;
    endcase
  end

  assign lane_mask = size_mask << bit_off;
  assign merge_o   = (dword_i & ~lane_mask) | ((wdata_i << bit_off) & lane_mask);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between pipeline and a doubleword data memory; sub-doubleword stores are read-modify-write.
// Latency: misaligned 1 cycle, load/SD 2 cycles, SB/SH/SW 3 cycles from accept to resp_valid.
// Backpressure: req_ready only in IDLE; one request in flight, response pulse cannot be stalled.
// Ports: clk/reset; req_* pipeline request (valid/ready); resp_* one-cycle completion;
//        MemRead/MemWrite/address/write_data/read_data doubleword memory interface.
module mem_access_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_is_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_misaligned,
  output logic            MemRead,
  output logic            MemWrite,
  output logic [XLEN-1:0] address,
  output logic [XLEN-1:0] write_data,
  input  logic [XLEN-1:0] read_data
);

  import mem_access_unit_pkg::*;

  state_e          state_q, state_d;
  logic            is_store_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata_q;
  logic            err_q;

  logic            accept;
  logic            req_err;
  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] merge_val;

  assign accept  = req_valid && (state_q == ST_IDLE);
  assign req_err = access_error(req_is_store, req_funct3, req_addr[2:0]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_err) begin
            state_d = ST_RESP;
          end else if (req_is_store && (req_funct3 == F3_D)) begin
            state_d = ST_WRITE;
          end else begin
            // loads, and sub-doubleword stores that need the old doubleword
            state_d = ST_READ;
          end
        end
      end
      ST_READ:  state_d = is_store_q ? ST_WRITE : ST_RESP;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        is_store_q <= req_is_store;
        funct3_q   <= req_funct3;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        err_q      <= req_err;
      end
      if (state_q == ST_READ) begin
        rdata_q <= read_data;
      end
    end
  end

  mem_lane_align u_lane_align (
    .funct3_i (funct3_q),
    .lane_i   (addr_q[2:0]),
    .dword_i  (rdata_q),
    .wdata_i  (wdata_q),
    .load_o   (load_val),
    .merge_o  (merge_val)
  );

  assign req_ready       = (state_q == ST_IDLE);
  assign MemRead         = (state_q == ST_READ);
  assign MemWrite        = (state_q == ST_WRITE);
  assign resp_valid      = (state_q == ST_RESP);
  assign resp_misaligned = resp_valid && err_q;
  assign resp_rdata      = (resp_valid && !err_q && !is_store_q) ? load_val : '0;

  // Memory side sees only registered request state, so both buses hold still
  // for the whole READ/WRITE cycle regardless of the pipeline inputs.
  assign address    = {3'b000, addr_q[XLEN-1:3]};
  assign write_data = (funct3_q[1:0] == 2'b11) ? wdata_q : merge_val;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_misaligned;
  logic        MemRead;
  logic        MemWrite;
  logic [63:0] address;
  logic [63:0] write_data;
  logic [63:0] read_data;

  always #5 clk = ~clk;

  mem_access_unit #(.XLEN(64)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_is_store    (req_is_store),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .MemRead         (MemRead),
    .MemWrite        (MemWrite),
    .address         (address),
    .write_data      (write_data),
    .read_data       (read_data)
  );

  // Memory seen by the DUT, plus a backdoor preload port for the bench.
  logic [63:0] mem     [0:15];
  logic [63:0] ref_mem [0:15];
  logic        pre_en = 1'b0;
  logic [3:0]  pre_idx = 4'd0;
  logic [63:0] pre_dat = 64'd0;

  always_comb read_data = MemRead ? mem[address[3:0]] : 64'd0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_dat;
    else if (MemWrite) mem[address[3:0]] <= write_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        misal;
    logic [63:0] rdata;
    logic [63:0] wd;
    int          nrd;
    int          nwr;
    int          lat;
    int          acc;
    logic [63:0] idx;
  } exp_t;

  exp_t sbq[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT responds.
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (reset) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      chk("rd_wr_overlap", {63'd0, MemRead & MemWrite}, 64'd0);
      if (MemRead || MemWrite) begin
        if (sbq.size() == 0) begin
          chk("mem_access_without_request", 64'd1, 64'd0);
        end else begin
          chk("address", address, sbq[0].idx);
          if (MemWrite) chk("write_data", write_data, sbq[0].wd);
        end
        if (MemRead)  rd_cnt++;
        if (MemWrite) wr_cnt++;
      end
      if (resp_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_resp", 64'd1, 64'd0);
        end else begin
          mon_e = sbq.pop_front();
          chk("resp_rdata", resp_rdata, mon_e.rdata);
          chk("resp_misaligned", {63'd0, resp_misaligned}, {63'd0, mon_e.misal});
          chk("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
          chk("memread_cycles", 64'(rd_cnt), 64'(mon_e.nrd));
          chk("memwrite_cycles", 64'(wr_cnt), 64'(mon_e.nwr));
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  // Reference model: byte-by-byte view of the access rules.
  function automatic exp_t model(input logic st, input logic [2:0] f3,
                                 input logic [63:0] addr, input logic [63:0] wdata);
    exp_t e;
    int n, lane;
    logic [63:0] d, v;
    n    = 1 << f3[1:0];
    lane = int'(addr[2:0]);
    e.idx = addr >> 3;
    e.rdata = 64'd0;
    e.wd = 64'd0;
    e.acc = 0;
    if ((st && f3[2]) || f3 == 3'b111 || (lane % n) != 0) begin
      e.misal = 1'b1; e.nrd = 0; e.nwr = 0; e.lat = 1;
    end else if (!st) begin
      d = ref_mem[e.idx[3:0]];
      v = 64'd0;
      for (int b = 0; b < n; b++) v[8*b +: 8] = d[8*(lane+b) +: 8];
      if (!f3[2] && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
      e.misal = 1'b0; e.rdata = v; e.nrd = 1; e.nwr = 0; e.lat = 2;
    end else begin
      d = ref_mem[e.idx[3:0]];
      for (int b = 0; b < n; b++) d[8*(lane+b) +: 8] = wdata[8*b +: 8];
      ref_mem[e.idx[3:0]] = d;
      e.misal = 1'b0; e.wd = d; e.nwr = 1;
      e.nrd = (n == 8) ? 0 : 1;
      e.lat = (n == 8) ? 2 : 3;
    end
    return e;
  endfunction

  // Presents a request (valid stays high on return) and records the handshake cycle.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic ovr,
                       input logic [63:0] ovr_rdata, input logic [63:0] ovr_wd,
                       output int acc, output int lat);
    exp_t e;
    int w;
    @(negedge clk);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    w = 0;
    while (!req_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", 64'd0, 64'd1);
      req_valid = 1'b0; acc = -1; lat = 0;
      return;
    end
    e = model(st, f3, addr, wdata);
    if (ovr) begin
      e.rdata = ovr_rdata;
      if (st) e.wd = ovr_wd;
    end
    e.acc = cyc;
    acc = cyc;
    lat = e.lat;
    sbq.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sbq.size() != 0; i++) @(negedge clk);
    chk("drain_pending", 64'(sbq.size()), 64'd0);
    sbq.delete();
  endtask

  task automatic preload(input int idx, input logic [63:0] dat);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx[3:0]; pre_dat = dat;
    @(negedge clk);
    pre_en = 1'b0;
    ref_mem[idx] = dat;
  endtask

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int a1, l1, a2, l2, pa, pl;
    logic st, b2b;
    logic [2:0] f3;
    logic [63:0] addr, wd, saved;
    exp_t dummy;

    reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 64'd0; req_wdata = 64'd0;
    repeat (2) @(negedge clk);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_resp_misaligned", {63'd0, resp_misaligned}, 64'd0);
    chk("rst_memread", {63'd0, MemRead}, 64'd0);
    chk("rst_memwrite", {63'd0, MemWrite}, 64'd0);
    chk("rst_address", address, 64'd0);
    chk("rst_write_data", write_data, 64'd0);
    for (int i = 0; i < 16; i++) preload(i, {$urandom, $urandom});
    @(negedge clk);
    reset = 1'b0;
    #1 chk("rst_req_ready", {63'd0, req_ready}, 64'd1);

    // Directed cases
    preload(3, 64'hDEADBEEFCAFEBABE);
    issue(1'b0, 3'b011, 64'h18, 64'd0, 1'b1, 64'hDEADBEEFCAFEBABE, 64'd0, a1, l1); idle(); drain();
    issue(1'b0, 3'b000, 64'h1F, 64'd0, 1'b1, 64'hFFFFFFFFFFFFFFDE, 64'd0, a1, l1); idle(); drain();
    issue(1'b0, 3'b100, 64'h1F, 64'd0, 1'b1, 64'h00000000000000DE, 64'd0, a1, l1); idle(); drain();
    preload(3, 64'h1122334455667788);
    issue(1'b1, 3'b000, 64'h19, 64'h55, 1'b1, 64'd0, 64'h1122334455665588, a1, l1); idle(); drain();
    chk("sb_mem_result", mem[3], 64'h1122334455665588);
    issue(1'b0, 3'b010, 64'h1A, 64'd0, 1'b0, 64'd0, 64'd0, a1, l1); idle(); drain();
    issue(1'b1, 3'b100, 64'h20, 64'h1234, 1'b0, 64'd0, 64'd0, a1, l1); idle(); drain();
    issue(1'b0, 3'b111, 64'h20, 64'd0, 1'b0, 64'd0, 64'd0, a1, l1); idle(); drain();

    // Back-to-back LD then SD with valid held
    issue(1'b0, 3'b011, 64'h20, 64'd0, 1'b0, 64'd0, 64'd0, a1, l1);
    issue(1'b1, 3'b011, 64'h28, 64'hA5A5_0F0F_1234_5678, 1'b0, 64'd0, 64'd0, a2, l2);
    idle();
    chk("b2b_accept_cycle", 64'(a2), 64'(a1 + l1 + 1));
    drain();

    // Randomized traffic, mixing held-valid back-to-back and idle gaps
    pa = -100; pl = 0;
    for (int t = 0; t < 300; t++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      addr = 64'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0) addr = addr & ~((64'd1 << f3[1:0]) - 64'd1);
      wd = {$urandom, $urandom};
      b2b = (pa >= 0);
      issue(st, f3, addr, wd, 1'b0, 64'd0, 64'd0, a1, l1);
      if (b2b) chk("no_bubble", 64'(a1), 64'(pa + pl + 1));
      if ($urandom_range(0, 1) == 0) begin
        pa = a1; pl = l1;
      end else begin
        idle();
        repeat ($urandom_range(0, 3)) @(negedge clk);
        pa = -100;
      end
    end
    idle();
    drain();

    // Reset in the middle of an SD write
    saved = ref_mem[5];
    dummy.misal = 1'b0; dummy.rdata = 64'd0; dummy.wd = 64'hFEED_FACE_0BAD_F00D;
    dummy.nrd = 0; dummy.nwr = 1; dummy.lat = 2; dummy.idx = 64'd5;
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b011;
    req_addr = 64'h28; req_wdata = 64'hFEED_FACE_0BAD_F00D;
    dummy.acc = cyc;
    sbq.push_back(dummy);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    #2 chk("abort_in_write", {63'd0, MemWrite}, 64'd1);
    reset = 1'b1;
    #1 chk("abort_memwrite_drop", {63'd0, MemWrite}, 64'd0);
    sbq.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 chk("abort_req_ready", {63'd0, req_ready}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_no_memwrite", {63'd0, MemWrite}, 64'd0);
      chk("abort_no_resp", {63'd0, resp_valid}, 64'd0);
    end
    chk("abort_mem_unchanged", mem[5], saved);

    // Unit still works after the abort
    issue(1'b0, 3'b011, 64'h28, 64'd0, 1'b0, 64'd0, 64'd0, a1, l1); idle(); drain();

    for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: XLEN, 64, data and address width; only 64 is supported.
REQ-002 Port: clk  in  1  single clock, all state updates on rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: req_valid  in  1  pipeline load/store request present.
REQ-005 Port: req_ready  out  1  unit can accept a request; high only in IDLE.
REQ-006 Port: req_is_store  in  1  1 = store, 0 = load.
REQ-007 Port: req_funct3  in  3  RISC-V width code: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU; stores use 000/001/010/011.
REQ-008 Port: req_addr  in  XLEN  byte address.
REQ-009 Port: req_wdata  in  XLEN  store data, LSB-aligned.
REQ-010 Port: resp_valid  out  1  one-cycle completion pulse.
REQ-011 Port: resp_rdata  out  XLEN  extended load result; 0 for stores.
REQ-012 Port: resp_misaligned  out  1  qualifies resp_valid; access not naturally aligned.
REQ-013 Port: MemRead  out  1  data memory read enable.
REQ-014 Port: MemWrite  out  1  data memory write enable.
REQ-015 Port: address  out  XLEN  doubleword index to memory, equal to {3'b0, addr[63:3]}.
REQ-016 Port: write_data  out  XLEN  full doubleword to memory.
REQ-017 Port: read_data  in  XLEN  memory read data, combinationally valid while MemRead is high; memory writes on the rising edge while MemWrite is high.

Function
REQ-018 FSM states IDLE, READ, WRITE, RESP; one-hot or binary encoding is free.
REQ-019 Accept = req_valid & req_ready at a rising edge; request fields registered on accept, inputs ignored afterwards.
REQ-020 Misaligned (LH/SH addr[0]!=0; LW/SW addr[1:0]!=0; LD/SD addr[2:0]!=0): IDLE->RESP, no MemRead/MemWrite, resp_misaligned=1, resp_rdata=0.
REQ-021 Load: IDLE->READ (MemRead=1 one cycle, read_data captured at edge) ->RESP->IDLE; resp_valid 2 cycles after accept.
REQ-022 Load extraction: byte lane = addr[2:0]; LB/LH/LW sign-extend, LBU/LHU/LWU zero-extend, LD full 64 bits.
REQ-023 SD: IDLE->WRITE (MemWrite=1, write_data=req_wdata) ->RESP; resp_valid 2 cycles after accept.
REQ-024 SB/SH/SW: IDLE->READ->WRITE->RESP; write_data = captured doubleword with only the addressed byte lanes replaced by req_wdata low bytes; resp_valid 3 cycles after accept.
REQ-025 MemRead and MemWrite never high in the same cycle; both low in IDLE and RESP.
REQ-026 address and write_data driven from registered request only; stable during READ and WRITE.
REQ-027 Store with funct3 1xx or 111 load: treated as misaligned-class error, resp_misaligned=1, no memory access.
REQ-028 resp_valid high exactly one cycle in RESP; RESP->IDLE unconditionally; req_ready low in RESP.
REQ-029 Back-to-back: request held valid in RESP cycle accepted in the following IDLE cycle; no bubble beyond that.

Reset
REQ-030 Reset asserted: FSM -> IDLE immediately, regardless of clk.
REQ-031 Reset values: req_ready=1 (once reset deasserts), resp_valid=0, resp_rdata=0, resp_misaligned=0, MemRead=0, MemWrite=0, address=0, write_data=0.
REQ-032 Reset during READ or WRITE aborts the access; no MemWrite pulse and no resp_valid for the aborted request.

Structure
REQ-033 Shared package holds funct3 width codes, FSM state typedef, XLEN constant.
REQ-034 One sub-module mem_lane_align: combinational byte-lane extract/extend and store merge; FSM stays in mem_access_unit.

Verification
REQ-035 LD addr 0x18, memory[3]=64'hDEADBEEFCAFEBABE -> address=3, MemRead one cycle, resp_rdata=64'hDEADBEEFCAFEBABE 2 cycles after accept.
REQ-036 LB addr 0x1F, same memory -> resp_rdata=64'hFFFFFFFFFFFFFFDE; LBU same addr -> 64'h00000000000000DE.
REQ-037 SB addr 0x19 wdata 0x55, memory[3]=64'h1122334455667788 -> read then write_data=64'h1122334455665588, resp_valid 3 cycles after accept.
REQ-038 LW addr 0x1A -> resp_misaligned=1 next cycle after accept, MemRead and MemWrite never asserted.
REQ-039 SD accepted then reset pulsed during WRITE -> no MemWrite edge observed after reset, no resp_valid, req_ready=1 after reset release.
REQ-040 LD then SD requested back-to-back with req_valid held -> second accept in the IDLE cycle after first RESP, MemRead/MemWrite never overlap.
